vliw_ctrl_seq: RTL
==================

Name: vliw_ctrl_seq

Overview:
- Registered, handshaked control-decode stage for one VLIW bundle: one 32-bit RV-style slot plus NUM_C16 compressed 16-bit slots.
- Generalises the per-slot combinational control decoders:
  - the compressed slot count is parametrised;
  - funct7 qualification is added;
  - an illegal-op flag is added;
  - memory ops from multiple compressed slots are serialised over a single memory port.
- Sits between fetch/bundle-split and the execute/register-file stage.

Parameters:
- NUM_C16, 2, number of compressed slots (1..8).
- SLOT_W, 3, width of mem_slot; must satisfy 2**SLOT_W >= NUM_C16.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard held bundle and abort the memory sequence.
- bundle_valid  in  1  bundle offered.
- bundle_ready  out  1  bundle accepted when valid&ready at the clk edge.
- op32_opcode/op32_funct3/op32_funct7  in  7/3/7  32-bit slot fields.
- c16_opcode  in  2*NUM_C16  slot i at [2i+1:2i].
- c16_funct  in  4*NUM_C16  slot i at [4i+3:4i].
- ctrl_valid  out  1  decoded bundle available.
- ctrl_ready  in  1  downstream consumes bundle.
- jump, branch, regWrite_32  out  1 each.
- aluSrcB, aluOp, writeDataSelect_32  out  2 each.
- rs2_select_16, memAdderSrcA, memAdderSrcB, regDest16_select, aluMemSelect, regWrite_16  out  NUM_C16 each, bit i = slot i.
- illegal  out  NUM_C16+1  bit 0 = 32-bit slot, bit i+1 = c16 slot i.
- memRead, memWrite  out  1  memory strobes.
- mem_slot  out  SLOT_W  slot currently using memory.
- mem_ack  in  1  memory completes the current access.

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset: state=IDLE, pending mask=0, every registered output=0; bundle_ready=0 while reset=1.
- States:
  - IDLE: empty.
  - MEM: memory ops pending.
  - OUT: ctrl_valid=1.
- bundle_ready is combinational: ((state==IDLE) | (state==OUT & ctrl_ready)) & !flush & !reset.
- Accept edge actions:
  - all control fields are decoded and registered;
  - pending mask = slots decoding as clw or csw;
  - next state = MEM if mask≠0, else OUT.
- Minimum latency: ctrl_valid is high in the cycle after the accept edge.
- 32-bit decode, listed as jump, branch, aluSrcB, aluOp, wds, rw:
  - 0010011 f3=000 addi: 0,0,10,00,00,1.
  - 0010011 f3=011 sltiu: 0,0,11,01,10,1.
  - 0010011 f3=101 with f7=0100000 srai: 0,0,01,10,00,1.
  - 0110011 f3=000 with f7=0100000 sub: 0,0,00,01,00,1.
  - 1100111 f3=000 jalr: 1,0,00,00,01,1.
  - 1100011 f3=100 blt: 0,1,00,00,00,0.
  - Anything else: all 0 and illegal[0]=1.
- c16 decode per slot:
  - op=10, funct=1000 cmv: regWrite_16=1, all other fields 0.
  - op=00, funct[3:1]=010 clw: rs2_select_16, memAdderSrcA, memAdderSrcB, regDest16_select, aluMemSelect, regWrite_16 all =1; memory read.
  - op=00, funct[3:1]=110 csw: rs2_select_16, memAdderSrcA, memAdderSrcB =1; memory write.
  - Anything else: fields 0, illegal[i+1]=1.
- Illegal bits do not block issue. They travel with the bundle.
- MEM state:
  - mem_slot = lowest set bit of the pending mask.
  - memRead/memWrite are driven combinationally from that slot's type.
  - The strobe is held until mem_ack is sampled high, which clears that bit.
  - Back-to-back slots keep the strobe high continuously; mem_slot changes on the ack edge.
  - Mask becomes 0 on an ack edge → OUT.
  - Strobes are 0 outside MEM. mem_ack is ignored outside MEM.
- OUT state:
  - Fields and ctrl_valid are held stable while ctrl_ready=0.
  - On ctrl_ready: retire. If a new bundle is accepted the same edge, go to MEM/OUT for it; otherwise go to IDLE and clear all fields to 0.
- flush, priority below reset:
  - next state=IDLE, mask=0, all fields and ctrl_valid cleared.
  - Any strobe is deasserted the next cycle, and a coincident mem_ack is dropped.
  - No accept occurs in the flush cycle.
- reset mid-MEM: same as flush, plus outputs return to their reset values.

Test Plan:
- Reset, then bundle {addi: 0010011/000; slot0 cmv: 10/1000; slot1 op=11} → ctrl_valid next cycle with aluSrcB=10, regWrite_32=1, regWrite_16=01, illegal=100.
- Slot0 clw and slot1 csw, mem_ack high 1 cycle after each request → memRead with mem_slot=0, then memWrite with mem_slot=1, ctrl_valid 3 cycles after accept, regWrite_16=01.
- srai with f7=0000000 → illegal[0]=1, regWrite_32=0; with f7=0100000 → aluOp=10, aluSrcB=01.
- ctrl_ready low for 4 cycles with a new bundle waiting → outputs stable, bundle_ready=0; ctrl_ready=1 → retire and accept on the same edge.
- flush during MEM with mem_ack coincident → next cycle IDLE, strobes 0, ctrl_valid 0, bundle_ready 1.
- jalr + blt in back-to-back bundles with ctrl_ready=1 continuously → jump=1, wds=01 then branch=1, regWrite_32=0, one bundle per cycle.

Source files
------------

// File: rtl/vliw_ctrl_seq.sv
// Registered control-decode stage for one VLIW bundle (one 32-bit slot plus
// NUM_C16 compressed slots); compressed loads/stores share one memory port.
module vliw_ctrl_seq #(
  parameter int NUM_C16 = 2,
  parameter int SLOT_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 bundle_valid,
  output logic                 bundle_ready,
  input  logic [6:0]           op32_opcode,
  input  logic [2:0]           op32_funct3,
  input  logic [6:0]           op32_funct7,
  input  logic [2*NUM_C16-1:0] c16_opcode,
  input  logic [4*NUM_C16-1:0] c16_funct,
  output logic                 ctrl_valid,
  input  logic                 ctrl_ready,
  output logic                 jump,
  output logic                 branch,
  output logic                 regWrite_32,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           aluOp,
  output logic [1:0]           writeDataSelect_32,
  output logic [NUM_C16-1:0]   rs2_select_16,
  output logic [NUM_C16-1:0]   memAdderSrcA,
  output logic [NUM_C16-1:0]   memAdderSrcB,
  output logic [NUM_C16-1:0]   regDest16_select,
  output logic [NUM_C16-1:0]   aluMemSelect,
  output logic [NUM_C16-1:0]   regWrite_16,
  output logic [NUM_C16:0]     illegal,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [SLOT_W-1:0]    mem_slot,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wds;
    logic       rw;
    logic       ill;
  } dec32_t;

  // Unrecognised encodings (including wrong funct7) decode to all-zero plus illegal.
  function automatic dec32_t decode32(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7);
    dec32_t d;
    d = '0;
    case ({opc, f3})
      {7'b0010011, 3'b000}: begin d.alu_src_b = 2'b10; d.rw = 1'b1; end
      {7'b0010011, 3'b011}: begin
        d.alu_src_b = 2'b11; d.alu_op = 2'b01; d.wds = 2'b10; d.rw = 1'b1;
      end
      {7'b0010011, 3'b101}: begin
        if (f7 == 7'b0100000) begin d.alu_src_b = 2'b01; d.alu_op = 2'b10; d.rw = 1'b1; end
        else begin d.ill = 1'b1; end
      end
      {7'b0110011, 3'b000}: begin
        if (f7 == 7'b0100000) begin d.alu_op = 2'b01; d.rw = 1'b1; end
        else begin d.ill = 1'b1; end
      end
      {7'b1100111, 3'b000}: begin d.jump = 1'b1; d.wds = 2'b01; d.rw = 1'b1; end
      {7'b1100011, 3'b100}: begin d.branch = 1'b1; end
      default:              begin d.ill = 1'b1; end
    endcase
    return d;
  endfunction

  function automatic logic [SLOT_W-1:0] lowest_set(input logic [NUM_C16-1:0] m);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_C16 - 1; i >= 0; i--) begin
      if (m[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  state_t             state_r, state_nx_s;
  logic [NUM_C16-1:0] mask_r, mask_nx_s, wr_mask_r, wr_mask_nx_s;
  logic [NUM_C16-1:0] low_onehot_s, mask_acked_s;
  logic               accept_s, clear_s, in_mem_s;

  dec32_t             dec32_s, dec32_r;
  logic [NUM_C16-1:0] rs2_s, srca_s, srcb_s, dest_s, alumem_s, rw16_s, ill16_s, ld_s, st_s;
  logic [NUM_C16-1:0] rs2_r, srca_r, srcb_r, dest_r, alumem_r, rw16_r, ill16_r;

  assign bundle_ready = ((state_r == ST_IDLE) | ((state_r == ST_OUT) & ctrl_ready))
                        & ~flush & ~reset;
  assign accept_s     = bundle_valid & bundle_ready;
  assign clear_s      = flush | ((state_r == ST_OUT) & ctrl_ready & ~accept_s);
  assign in_mem_s     = (state_r == ST_MEM);
  assign dec32_s      = decode32(op32_opcode, op32_funct3, op32_funct7);

  // Per-slot compressed decode of the offered bundle.
  always_comb begin
    rs2_s    = '0;
    srca_s   = '0;
    srcb_s   = '0;
    dest_s   = '0;
    alumem_s = '0;
    rw16_s   = '0;
    ill16_s  = '0;
    ld_s     = '0;
    st_s     = '0;
    for (int i = 0; i < NUM_C16; i++) begin
      case (c16_opcode[2*i +: 2])
        2'b10: begin
          if (c16_funct[4*i +: 4] == 4'b1000) rw16_s[i] = 1'b1;
          else ill16_s[i] = 1'b1;
        end
        2'b00: begin
          case (c16_funct[4*i+1 +: 3])
            3'b010: begin
              rs2_s[i] = 1'b1; srca_s[i] = 1'b1; srcb_s[i] = 1'b1;
              dest_s[i] = 1'b1; alumem_s[i] = 1'b1; rw16_s[i] = 1'b1; ld_s[i] = 1'b1;
            end
            3'b110: begin
              rs2_s[i] = 1'b1; srca_s[i] = 1'b1; srcb_s[i] = 1'b1; st_s[i] = 1'b1;
            end
            default: ill16_s[i] = 1'b1;
          endcase
        end
        default: ill16_s[i] = 1'b1;
      endcase
    end
  end

  // Lowest pending slot owns the memory port; an ack retires exactly that slot.
  assign low_onehot_s = mask_r & (~mask_r + NUM_C16'(1));
  assign mask_acked_s = mask_r & ~low_onehot_s;
  assign memRead      = in_mem_s & (|(low_onehot_s & ~wr_mask_r));
  assign memWrite     = in_mem_s & (|(low_onehot_s & wr_mask_r));
  assign mem_slot     = in_mem_s ? lowest_set(mask_r) : {SLOT_W{1'b0}};

  // Next-state and pending-mask logic.
  always_comb begin
    state_nx_s   = state_r;
    mask_nx_s    = mask_r;
    wr_mask_nx_s = wr_mask_r;
    if (flush) begin
      state_nx_s   = ST_IDLE;
      mask_nx_s    = '0;
      wr_mask_nx_s = '0;
    end else if (accept_s) begin
      mask_nx_s    = ld_s | st_s;
      wr_mask_nx_s = st_s;
      state_nx_s   = ((ld_s | st_s) != '0) ? ST_MEM : ST_OUT;
    end else begin
      case (state_r)
        ST_MEM: begin
          if (mem_ack) begin
            mask_nx_s  = mask_acked_s;
            state_nx_s = (mask_acked_s == '0) ? ST_OUT : ST_MEM;
          end else begin
            state_nx_s = ST_MEM;
          end
        end
        ST_OUT:  state_nx_s = ctrl_ready ? ST_IDLE : ST_OUT;
        ST_IDLE: state_nx_s = ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State and pending-mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mask_r    <= '0;
      wr_mask_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      mask_r    <= mask_nx_s;
      wr_mask_r <= wr_mask_nx_s;
    end
  end

  // Decoded fields load on accept and hold until retire or flush.
  always_ff @(posedge clk) begin
    if (reset || clear_s) begin
      dec32_r  <= '0;
      rs2_r    <= '0;
      srca_r   <= '0;
      srcb_r   <= '0;
      dest_r   <= '0;
      alumem_r <= '0;
      rw16_r   <= '0;
      ill16_r  <= '0;
    end else if (accept_s) begin
      dec32_r  <= dec32_s;
      rs2_r    <= rs2_s;
      srca_r   <= srca_s;
      srcb_r   <= srcb_s;
      dest_r   <= dest_s;
      alumem_r <= alumem_s;
      rw16_r   <= rw16_s;
      ill16_r  <= ill16_s;
    end else begin
      dec32_r  <= dec32_r;
    end
  end

  assign ctrl_valid         = (state_r == ST_OUT);
  assign jump               = dec32_r.jump;
  assign branch             = dec32_r.branch;
  assign regWrite_32        = dec32_r.rw;
  assign aluSrcB            = dec32_r.alu_src_b;
  assign aluOp              = dec32_r.alu_op;
  assign writeDataSelect_32 = dec32_r.wds;
  assign rs2_select_16      = rs2_r;
  assign memAdderSrcA       = srca_r;
  assign memAdderSrcB       = srcb_r;
  assign regDest16_select   = dest_r;
  assign aluMemSelect       = alumem_r;
  assign regWrite_16        = rw16_r;
  assign illegal            = {ill16_r, dec32_r.ill};

endmodule
